// File: rtl/mem_mult_sweeper_if.sv
// Host and SRAM-side signal bundle for mem_mult_sweeper.
// Uses the host-side modport for the bench/host and the slave modport for the engine.
interface mem_mult_sweeper_if #(
    parameter int DW = 52,
    parameter int AW = 7
);
    logic              start;
    logic              mode;
    logic [AW-1:0]     base_addr;
    logic [AW-1:0]     end_addr;
    logic [DW-1:0]     mem_do;
    logic              mem_nce;
    logic              mem_nwrt;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic              busy;
    logic              done;
    logic [DW-1:0]     prod_out;
    logic [DW+AW-1:0]  acc_out;

    modport master (
        output start, mode, base_addr, end_addr, mem_do,
        input  mem_nce, mem_nwrt, mem_addr, mem_din, busy, done, prod_out, acc_out
    );
    modport slave (
        input  start, mode, base_addr, end_addr, mem_do,
        output mem_nce, mem_nwrt, mem_addr, mem_din, busy, done, prod_out, acc_out
    );
endinterface

// File: rtl/mem_mult_sweeper.sv
// SRAM sweep engine: reads each word in [base..end], multiplies its upper half by its
// lower half, then writes the product back in place (mode 0) or only accumulates it (mode 1).
module mem_mult_sweeper #(
    parameter int DW      = 52,
    parameter int AW      = 7,
    parameter int MUL_LAT = 2
) (
    input logic              clk,
    input logic              rstn,
    mem_mult_sweeper_if.slave bus
);
    localparam int HW = DW / 2;
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [2:0] {IDLE, READ, CAPT, MUL, WRITE, DONE} state_t;

    state_t                      r_state, w_nxt;
    logic                        r_mode;
    logic [AW-1:0]               r_addr, r_end;
    logic [HW-1:0]               r_a, r_b;
    logic [CW-1:0]               r_cnt;
    logic [MUL_LAT-1:0][DW-1:0]  r_pipe;
    logic [DW-1:0]               w_mul, w_last_in, w_prod;
    logic [DW-1:0]               r_din, r_prod;
    logic [DW+AW-1:0]            r_acc;

    // Zero-extended operands give the exact DW-bit product.
    assign w_mul  = {{HW{1'b0}}, r_a} * {{HW{1'b0}}, r_b};
    assign w_prod = r_pipe[MUL_LAT-1];

    // Operands are stable through MUL, so the pipe can shift every cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_mul;
            for (int i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    // Value entering the last pipe stage, so write data is registered in time for WRITE.
    generate
        if (MUL_LAT == 1) begin : g_lat1
            assign w_last_in = w_mul;
        end else begin : g_latn
            assign w_last_in = r_pipe[MUL_LAT-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_nxt = READ;
            READ:    w_nxt = CAPT;
            CAPT:    w_nxt = MUL;
            MUL:     if (r_cnt == CW'(MUL_LAT - 1)) w_nxt = WRITE;
            WRITE:   w_nxt = (r_addr == r_end) ? DONE : READ;
            DONE:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode <= 1'b0;
            r_addr <= '0;
            r_end  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_din  <= '0;
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            r_cnt <= (r_state == MUL) ? r_cnt + CW'(1) : '0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_mode <= bus.mode;
                    r_addr <= bus.base_addr;
                    r_end  <= bus.end_addr;
                    r_acc  <= '0;
                end
                CAPT: begin
                    r_a <= bus.mem_do[DW-1:HW];
                    r_b <= bus.mem_do[HW-1:0];
                end
                WRITE: begin
                    r_prod <= w_prod;
                    r_acc  <= r_acc + {{AW{1'b0}}, w_prod};
                    if (r_addr != r_end) r_addr <= r_addr + AW'(1);
                end
                default: ;
            endcase
            if (w_nxt == WRITE && !r_mode) r_din <= w_last_in;
        end
    end

    assign bus.mem_nce  = !((r_state == READ) || (r_state == WRITE && !r_mode));
    assign bus.mem_nwrt = !(r_state == WRITE && !r_mode);
    assign bus.mem_addr = r_addr;
    assign bus.mem_din  = r_din;
    assign bus.busy     = (r_state == READ) || (r_state == CAPT) ||
                          (r_state == MUL)  || (r_state == WRITE);
    assign bus.done     = (r_state == DONE);
    assign bus.prod_out = r_prod;
    assign bus.acc_out  = r_acc;
endmodule

// File: tb/tb_mem_mult_sweeper.sv
// Directed bench for mem_mult_sweeper with a behavioural SRAM and a write scoreboard.
module tb_mem_mult_sweeper;
    localparam int DW = 52;
    localparam int AW = 7;
    localparam int ML = 2;
    localparam int WC = ML + 3;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_mult_sweeper_if #(.DW(DW), .AW(AW)) bus ();
    mem_mult_sweeper #(.DW(DW), .AW(AW), .MUL_LAT(ML)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pk_we = 1'b0;
    logic [AW-1:0] pk_a = '0;
    logic [DW-1:0] pk_d = '0;
    wr_t           exp_q[$];
    int            n_chk = 0;
    int            n_fail = 0;

    always @(posedge clk) begin
        if (pk_we) mem[pk_a] <= pk_d;
        else if (!bus.mem_nce) begin
            if (!bus.mem_nwrt) mem[bus.mem_addr] <= bus.mem_din;
            else               bus.mem_do <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the next scoreboard entry, in order.
    always @(negedge clk) begin
        if (rstn && bus.mem_nce === 1'b0 && bus.mem_nwrt === 1'b0) begin
            if (exp_q.size() == 0) chk("unexpected_write", 64'(bus.mem_addr), 64'hDEAD);
            else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write_addr", 64'(bus.mem_addr), 64'(w.a));
                chk("write_data", 64'(bus.mem_din), 64'(w.d));
            end
        end
    end

    function automatic logic [DW-1:0] prod(input logic [DW-1:0] w);
        logic [DW-1:0] a, b;
        a = {26'b0, w[DW-1:DW/2]};
        b = {26'b0, w[DW/2-1:0]};
        return a * b;
    endfunction

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pk_we = 1'b1; pk_a = a; pk_d = d;
        @(posedge clk); #1;
        pk_we = 1'b0;
    endtask

    // Runs one sweep; entered and left at 1 time unit after a rising edge.
    task automatic sweep(input logic [AW-1:0] b, input logic [AW-1:0] e, input logic m,
                         input int glitch);
        logic [AW-1:0] d, a;
        logic [DW-1:0] p, lastp;
        logic [63:0]   acc;
        int            n, cyc, lim;
        d = e - b; n = int'(d) + 1; acc = 0; lastp = 0;
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            p = prod(mem[a]);
            acc += 64'(p);
            lastp = p;
            if (!m) exp_q.push_back('{a: a, d: p});
        end
        bus.mode = m; bus.base_addr = b; bus.end_addr = e; bus.start = 1'b1;
        @(posedge clk); #1;
        cyc = 0; lim = n * WC + 20;
        while (1) begin
            bus.start = (cyc == glitch);
            if (cyc == glitch) begin
                bus.mode = ~m; bus.base_addr = b + AW'(3); bus.end_addr = b + AW'(3);
            end
            @(negedge clk);
            if (cyc == 0) chk("busy_after_start", 64'(bus.busy), 64'd1);
            if (bus.done === 1'b1 || cyc >= lim) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_cycle", 64'(cyc), 64'(n * WC));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        chk("prod_out", 64'(bus.prod_out), 64'(lastp));
        chk("acc_out", 64'(bus.acc_out), acc);
        chk("writes_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("done_pulse_end", 64'(bus.done), 64'd0);
        chk("idle_after_done", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] snap [0:3];
        logic [63:0]   rnd;
        logic [DW-1:0] p1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.base_addr = '0; bus.end_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nce", 64'(bus.mem_nce), 64'd1);
        chk("rst_nwrt", 64'(bus.mem_nwrt), 64'd1);
        chk("rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_din", 64'(bus.mem_din), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_prod", 64'(bus.prod_out), 64'd0);
        chk("rst_acc", 64'(bus.acc_out), 64'd0);
        rstn = 1'b1;
        for (int i = 0; i < (1 << AW); i++) begin
            rnd = {$urandom(), $urandom()};
            poke(AW'(i), rnd[DW-1:0]);
        end

        // Single word, write-back
        poke(7'd5, {26'd3, 26'd7});
        sweep(7'd5, 7'd5, 1'b0, -1);
        chk("single_prod", 64'(bus.prod_out), 64'd21);
        chk("single_acc", 64'(bus.acc_out), 64'd21);
        chk("single_mem", 64'(mem[5]), 64'd21);

        // Wrap-around 126,127,0,1
        sweep(7'd126, 7'd1, 1'b0, -1);

        // Accumulate only; memory must stay unchanged
        poke(7'd0, {26'd1, 26'd2}); poke(7'd1, {26'd3, 26'd4});
        poke(7'd2, {26'd5, 26'd6}); poke(7'd3, {26'd7, 26'd8});
        for (int i = 0; i < 4; i++) snap[i] = mem[i];
        sweep(7'd0, 7'd3, 1'b1, -1);
        chk("accum_acc", 64'(bus.acc_out), 64'd100);
        for (int i = 0; i < 4; i++) chk("accum_mem_kept", 64'(mem[i]), 64'(snap[i]));

        // Max operands
        poke(7'd9, {26'h3FFFFFF, 26'h3FFFFFF});
        sweep(7'd9, 7'd9, 1'b0, -1);
        chk("max_prod", 64'(bus.prod_out), 64'hFFFFFF8000001);
        chk("max_mem", 64'(mem[9]), 64'hFFFFFF8000001);

        // start while busy, and start during DONE, both ignored
        sweep(7'd40, 7'd43, 1'b0, 2);
        sweep(7'd50, 7'd50, 1'b0, WC);

        // Full-range accumulate (base = end + 1)
        sweep(7'd10, 7'd9, 1'b1, -1);

        // Reset during MUL of word 2 of a 4-word sweep
        for (int i = 0; i < 4; i++) snap[i] = mem[20 + i];
        p1 = prod(mem[20]);
        exp_q.push_back('{a: 7'd20, d: p1});
        bus.mode = 1'b0; bus.base_addr = 7'd20; bus.end_addr = 7'd23; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (WC + 2) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_nce", 64'(bus.mem_nce), 64'd1);
        chk("midrst_nwrt", 64'(bus.mem_nwrt), 64'd1);
        chk("midrst_addr", 64'(bus.mem_addr), 64'd0);
        chk("midrst_din", 64'(bus.mem_din), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_prod", 64'(bus.prod_out), 64'd0);
        chk("midrst_acc", 64'(bus.acc_out), 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_writes_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("midrst_word1", 64'(mem[20]), 64'(p1));
        for (int i = 1; i < 4; i++) chk("midrst_untouched", 64'(mem[20 + i]), 64'(snap[i]));
        sweep(7'd20, 7'd23, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_mult_sweeper.md
# mem_mult_sweeper

Parametrised memory sweep engine for a single-port synchronous SRAM: on a start pulse it walks an address range, reads each word, multiplies its upper half by its lower half through an internal MUL_LAT-stage pipelined unsigned multiplier, and either writes the product back in place or accumulates it. It sits between a host/test controller and the `rflp`-class SRAM macro, and drives the macro's active-low NCE/NWRT pins directly.

## Interface
- DW, 52: memory word width; must be even; operands are DW/2 bits each.
- AW, 7: address width; depth = 2^AW.
- MUL_LAT, 2: multiplier pipeline stages (>= 1).
- clk  in  1  clock; all state changes on rising edge.
- rstn  in  1  reset; asynchronous assert, active-low. One clock, `clk`; reset is asynchronous and active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- mode  in  1  0 = write product back; 1 = accumulate only (no writes). Latched at start.
- base_addr  in  AW  first address; latched at start.
- end_addr  in  AW  last address, inclusive; latched at start.
- mem_do  in  DW  SRAM read data; valid in the cycle after a read access.
- mem_nce  out  1  SRAM chip enable, active-low.
- mem_nwrt  out  1  SRAM write enable, active-low.
- mem_addr  out  AW  SRAM address.
- mem_din  out  DW  SRAM write data.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle completion pulse.
- prod_out  out  DW  most recent product.
- acc_out  out  DW+AW  running sum of products for the current sweep.

## Operation
- States: IDLE, READ, CAPT, MUL, WRITE, DONE.
- IDLE: start=1 latches mode, base/end; loads addr=base_addr; clears acc_out; -> READ. start while not IDLE is ignored.
- READ (1 cycle): mem_nce=0, mem_nwrt=1, mem_addr=addr. -> CAPT.
- CAPT (1 cycle): mem_do registered into operand A = mem_do[DW-1:DW/2], B = mem_do[DW/2-1:0]. -> MUL.
- MUL (MUL_LAT cycles, internal counter): unsigned A*B propagates; exact DW-bit result, no truncation. -> WRITE.
- WRITE (1 cycle): prod_out <= product; acc_out <= acc_out + product. mode 0: mem_nce=0, mem_nwrt=0, mem_addr=addr, mem_din=product. mode 1: mem_nce=1, mem_nwrt=1. If addr==end_addr -> DONE, else addr <= addr+1 (mod 2^AW) -> READ.
- DONE (1 cycle): done=1, busy=0. -> IDLE.
- Words processed N = ((end_addr - base_addr) mod 2^AW) + 1; end_addr < base_addr wraps through 2^AW-1 -> 0. base==end processes exactly one word. Full-range sweep is base=end+1 (mod 2^AW).
- mem_nce/mem_nwrt are 1 in every state not listed above. mem_addr/mem_din hold their last value outside accesses.
- acc_out width DW+AW cannot overflow (N <= 2^AW).
- rstn low at any time, including mid-sweep: immediately IDLE; no further memory access; a write in progress is abandoned.

## Timing
- Reset values: mem_nce=1, mem_nwrt=1, mem_addr=0, mem_din=0, busy=0, done=0, prod_out=0, acc_out=0.
- Per word: MUL_LAT+3 cycles (5 at default).
- done is high for the one cycle beginning N*(MUL_LAT+3) rising edges after the edge that sampled start; busy falls in that same cycle.
- A new start is accepted on the edge that ends DONE? No: only in IDLE, i.e. at the earliest one cycle after done.
- Memory control outputs are decoded from registered state only; no combinational path from any input to any output.

## Test plan
- Single word, mode 0: mem[5]={26'd3,26'd7}, base=end=5 -> one write of 52'd21 to address 5, prod_out=21, acc_out=21, done 5 cycles after start.
- Wrap-around, mode 0: base=126, end=1 -> reads/writes in order 126,127,0,1, exactly 4 writes, done after 20 cycles.
- Accumulate, mode 1: mem[0..3]=(1,2),(3,4),(5,6),(7,8), base=0, end=3 -> acc_out=100, mem_nwrt never 0, memory unchanged.
- Max operands: mem[9]={26'h3FFFFFF,26'h3FFFFFF} -> written value 52'hFFFFFF8000001.
- start pulsed while busy, and with new base/mode -> ignored; original sweep completes unchanged.
- rstn low during MUL of word 2 of a 4-word sweep -> all outputs to reset values within the reset cycle, no later access; next start runs a full clean sweep.
